aggregator_stream_reader: RTL and testbench
===========================================

# aggregator_stream_reader

Read-side counterpart of the data aggregator's 128-to-32 output FIFO: pops 32-bit words on the Ethernet-side clock, rebuilds the 256-bit records (8 words, MSB word first), and checks record framing. Drops the aggregator's idle filler records, forwards channel data records through a valid/ready handshake to the packet builder, and keeps record, idle and framing-error counters for slow-control readout.

## Interface
Parameters:
- IDLE_W0, 32'h3C5C7C5C, idle record word 0
- IDLE_W3, 32'h12344321, idle record word 3
- IDLE_W4, 32'h7D6D7A5A, idle record word 4
- IDLE_W7, 32'h55666655, idle record word 7; also the hunt re-sync marker

Ports:
- fifo_rd_clk  in  1  sole clock (Ethernet-side FIFO read clock)
- rst  in  1  reset, synchronous, active-high
- fifo_dout  in  32  FIFO read data, valid the cycle after fifo_rd_en (standard read, latency 1)
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  FIFO read enable
- rec_data  out  256  assembled record; word k occupies bits [255-32k -: 32]
- rec_chan  out  4  rec_data[254:251], channel id (0-7 Rx, 8 Tx)
- rec_valid  out  1  record valid
- rec_ready  in  1  downstream accept
- rec_count  out  32  forwarded records, wraps
- idle_count  out  32  dropped idle records, wraps
- sync_err_count  out  16  framing errors, saturates at 16'hFFFF
- in_sync  out  1  high when not in HUNT

## Operation
- States: HUNT, COLLECT.
- HUNT, entered from reset and on any framing error: read and discard words. When a captured word equals IDLE_W7, go to COLLECT with the word index set to 0.
- COLLECT: the captured word goes to index w (0..7), and w increments. After word 7:
  - Idle record (words 0,1,2,3,4,5,6,7 = IDLE_W0,0,0,IDLE_W3,IDLE_W4,0,0,IDLE_W7): discard it and increment idle_count.
  - Data record (word0[31] = 1, not idle): move it to the output register and increment rec_count on handoff.
  - Otherwise: framing error. Increment sync_err_count (saturating), discard the record, go to HUNT.
- Early check: if word 0 has bit 31 = 0 and is not IDLE_W0, this is a framing error immediately. Increment sync_err_count, discard, go to HUNT; remaining words are hunted, not collected.
- Output register: rec_valid is set on handoff. rec_data and rec_chan are stable while rec_valid && !rec_ready. rec_valid clears on the cycle after acceptance unless a new record is handed off that same cycle.
- Backpressure: the assembly buffer holds one record (captured + in-flight words ≤ 8).
  - Reading stops once 8 words are captured or in flight and the output register is occupied and not being accepted.
  - A completed record transfers on the cycle the register is empty or rec_ready is high.
  - No FIFO word is ever lost or duplicated.
- fifo_rd_en = !fifo_empty && !rst && !(assembly full-or-pending && output blocked).
- Counters advance by at most 1 per cycle each. rec_count and idle_count wrap 32'hFFFFFFFF → 0.

## Timing
- Reset values: fifo_rd_en 0, rec_valid 0, rec_data 0, rec_chan 0, all counters 0, in_sync 0, state HUNT, w 0.
- Reset asserted mid-record discards any partial record and any pending output. The first cycle after rst falls may assert fifo_rd_en.
- Read latency: a word read at cycle n is captured at n+1.
- Latency, FIFO never empty, output free:
  - reads at cycles 0..7, captures at 1..8;
  - rec_valid high at cycle 9;
  - the next record's first read may be issued at cycle 8 (full streaming, one word per cycle).
- fifo_empty mid-record: fifo_rd_en drops and w holds; no timeout.
- Counter updates are visible one cycle after the capture of word 7 (the word 0 capture for the early check).
- in_sync is registered: high the cycle after the IDLE_W7 match, low the cycle after the framing error capture.

## Test plan
- Reset, then FIFO supplies IDLE_W7 and then one data record with word0 = 32'hC0000001 and words 1-7 = 1..7 → in_sync = 1. rec_valid rises 9 cycles after the first record read. rec_chan = 8, rec_data[255:224] = 32'hC0000001, rec_count = 1.
- Three idle records back-to-back after sync → no rec_valid, idle_count = 3, fifo_rd_en continuously high.
- Word0 = 32'h12345678 (bit31 = 0) after sync → sync_err_count = 1, in_sync = 0. The following words are discarded until IDLE_W7, then the next data record is forwarded.
- Hold rec_ready = 0 with 3 data records queued → first record held stable, reading stops after 8 words of the second record are pending. Pulse rec_ready → records emerge in order with no loss, rec_count = 3.
- fifo_empty toggled every other cycle during a record → correct reassembly, word order MSB-first preserved.
- Assert rst after 4 words of a record → all outputs return to reset values next cycle. After release the bench must resync via IDLE_W7 before any record is forwarded.

Source files
------------

// File: rtl/aggregator_stream_reader_if.sv
// FIFO read port and record valid/ready handshake of the aggregator stream reader.
// master = the reader itself, slave = the FIFO/packet-builder side.
interface aggregator_stream_reader_if;
    logic [31:0]  fifo_dout;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [255:0] rec_data;
    logic [3:0]   rec_chan;
    logic         rec_valid;
    logic         rec_ready;

    modport master (
        input  fifo_dout, fifo_empty, rec_ready,
        output fifo_rd_en, rec_data, rec_chan, rec_valid
    );
    modport slave (
        output fifo_dout, fifo_empty, rec_ready,
        input  fifo_rd_en, rec_data, rec_chan, rec_valid
    );
endinterface

// File: rtl/aggregator_stream_reader.sv
// Rebuilds 256-bit aggregator records from the 32-bit output FIFO, drops idle filler,
// forwards data records over valid/ready and re-hunts on framing errors.
module aggregator_stream_reader #(
    parameter logic [31:0] IDLE_W0 = 32'h3C5C7C5C,
    parameter logic [31:0] IDLE_W3 = 32'h12344321,
    parameter logic [31:0] IDLE_W4 = 32'h7D6D7A5A,
    parameter logic [31:0] IDLE_W7 = 32'h55666655
) (
    input  logic                        fifo_rd_clk,
    input  logic                        rst,
    aggregator_stream_reader_if.master  bus,
    output logic [31:0]                 rec_count,
    output logic [31:0]                 idle_count,
    output logic [15:0]                 sync_err_count,
    output logic                        in_sync
);
    localparam logic [255:0] IDLE_REC = {IDLE_W0, 32'h0, 32'h0, IDLE_W3,
                                         IDLE_W4, 32'h0, 32'h0, IDLE_W7};

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t       state, state_nx;
    logic [3:0]   w, w_nx;        // 8 = complete record parked, waiting for the output register
    logic         rd_vld;         // fifo_dout carries a freshly read word this cycle
    logic [31:0]  words [8];
    logic [255:0] asm_rec;
    logic         out_blocked, asm_full;
    logic         cap, handoff, inc_idle, inc_err;

    assign out_blocked    = bus.rec_valid && !bus.rec_ready;
    assign asm_full       = ({1'b0, w} + {4'd0, rd_vld}) >= 5'd8;
    assign bus.fifo_rd_en = !bus.fifo_empty && !rst && !(asm_full && out_blocked);

    // Word 7 is taken straight off the FIFO so a record can hand off on its final capture.
    always_comb begin
        for (int k = 0; k < 7; k++) asm_rec[255-32*k -: 32] = words[k];
        asm_rec[31:0] = (w == 4'd8) ? words[7] : bus.fifo_dout;
    end

    always_comb begin
        state_nx = state;
        w_nx     = w;
        cap      = 1'b0;
        handoff  = 1'b0;
        inc_idle = 1'b0;
        inc_err  = 1'b0;
        case (state)
            HUNT: begin
                if (rd_vld && bus.fifo_dout == IDLE_W7) begin
                    state_nx = COLLECT;
                    w_nx     = 4'd0;
                end
            end
            COLLECT: begin
                if (w == 4'd8) begin
                    if (!out_blocked) begin
                        handoff = 1'b1;
                        w_nx    = 4'd0;
                    end
                end else if (rd_vld) begin
                    if (w == 4'd0 && !bus.fifo_dout[31] && bus.fifo_dout != IDLE_W0) begin
                        inc_err  = 1'b1;
                        state_nx = HUNT;
                        w_nx     = 4'd0;
                    end else if (w != 4'd7) begin
                        cap  = 1'b1;
                        w_nx = w + 4'd1;
                    end else if (asm_rec == IDLE_REC) begin
                        inc_idle = 1'b1;
                        w_nx     = 4'd0;
                    end else if (asm_rec[255]) begin
                        if (out_blocked) begin
                            cap  = 1'b1;
                            w_nx = 4'd8;
                        end else begin
                            handoff = 1'b1;
                            w_nx    = 4'd0;
                        end
                    end else begin
                        inc_err  = 1'b1;
                        state_nx = HUNT;
                        w_nx     = 4'd0;
                    end
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge fifo_rd_clk) begin
        if (cap) words[w[2:0]] <= bus.fifo_dout;
    end

    always_ff @(posedge fifo_rd_clk) begin
        if (rst) begin
            state          <= HUNT;
            w              <= 4'd0;
            rd_vld         <= 1'b0;
            in_sync        <= 1'b0;
            bus.rec_valid  <= 1'b0;
            bus.rec_data   <= '0;
            bus.rec_chan   <= '0;
            rec_count      <= '0;
            idle_count     <= '0;
            sync_err_count <= '0;
        end else begin
            state   <= state_nx;
            w       <= w_nx;
            rd_vld  <= bus.fifo_rd_en;
            in_sync <= (state_nx == COLLECT);
            if (handoff) begin
                bus.rec_valid <= 1'b1;
                bus.rec_data  <= asm_rec;
                bus.rec_chan  <= asm_rec[254:251];
                rec_count     <= rec_count + 32'd1;
            end else if (bus.rec_ready) begin
                bus.rec_valid <= 1'b0;
            end
            if (inc_idle) idle_count <= idle_count + 32'd1;
            if (inc_err && sync_err_count != 16'hFFFF) sync_err_count <= sync_err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_aggregator_stream_reader.sv
// Directed bench: FIFO model, word-stream reference model with a record scoreboard,
// per-cycle counter/sync checks plus literal checkpoints per scenario.
module tb_aggregator_stream_reader;
    localparam logic [31:0] IW0 = 32'h3C5C7C5C;
    localparam logic [31:0] IW3 = 32'h12344321;
    localparam logic [31:0] IW4 = 32'h7D6D7A5A;
    localparam logic [31:0] IW7 = 32'h55666655;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aggregator_stream_reader_if bus();
    logic [31:0] rec_count, idle_count;
    logic [15:0] sync_err_count;
    logic        in_sync;

    aggregator_stream_reader #(.IDLE_W0(IW0), .IDLE_W3(IW3), .IDLE_W4(IW4), .IDLE_W7(IW7)) dut (
        .fifo_rd_clk(clk), .rst(rst), .bus(bus.master),
        .rec_count(rec_count), .idle_count(idle_count),
        .sync_err_count(sync_err_count), .in_sync(in_sync)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, take_cyc = 0, rd0_cyc = -1, rise_cyc = -1, n_rise = 0;
    logic [31:0] fq [$];
    bit toggle = 0, take = 0, cap_vld = 0;

    // reference model state
    bit           m_hunt = 1;
    logic [31:0]  m_cur [$];
    logic [255:0] m_exp [$];
    int           m_idle = 0, m_err = 0;

    logic         pv = 0, pblk = 0;
    logic [255:0] pdata = '0, last_acc = '0;
    logic [3:0]   last_chan = '0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1; m_cur.delete(); m_exp.delete(); m_idle = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [31:0] wd);
        logic [255:0] r;
        if (m_hunt) begin
            if (wd == IW7) begin m_hunt = 0; m_cur.delete(); end
        end else if (m_cur.size() == 0 && !wd[31] && wd != IW0) begin
            m_err++; m_hunt = 1;
        end else begin
            m_cur.push_back(wd);
            if (m_cur.size() == 8) begin
                for (int k = 0; k < 8; k++) r[255-32*k -: 32] = m_cur[k];
                if (r == {IW0, 32'h0, 32'h0, IW3, IW4, 32'h0, 32'h0, IW7}) m_idle++;
                else if (r[255]) m_exp.push_back(r);
                else begin m_err++; m_hunt = 1; end
                m_cur.delete();
            end
        end
    endtask

    task automatic push_rec(input logic [31:0] w0, input logic [31:0] base);
        fq.push_back(w0);
        for (int k = 1; k < 8; k++) fq.push_back(base + k);
    endtask

    task automatic push_idle();
        fq.push_back(IW0); fq.push_back(0); fq.push_back(0); fq.push_back(IW3);
        fq.push_back(IW4); fq.push_back(0); fq.push_back(0); fq.push_back(IW7);
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (fq.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk({nm, "_drain"}, n < 400, 1'b1);
        repeat (14) @(negedge clk);
    endtask

    // FIFO model + compare process
    initial begin
        logic [255:0] e;
        bus.fifo_dout = '0; bus.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            chk("in_sync", in_sync, !m_hunt);
            chk("idle_count", idle_count, m_idle);
            chk("sync_err_count", sync_err_count, m_err);
            if (pblk) begin
                chk("hold_valid", bus.rec_valid, 1'b1);
                chk("hold_data", bus.rec_data, pdata);
            end
            if (bus.rec_valid && !pv) begin
                n_rise++;
                if (rise_cyc < 0 && rd0_cyc >= 0) rise_cyc = cyc;
            end
            if (bus.rec_valid && bus.rec_ready && !rst) begin
                chk("rec_expected", m_exp.size() > 0, 1'b1);
                if (m_exp.size() > 0) begin
                    e = m_exp.pop_front();
                    chk("rec_data", bus.rec_data, e);
                    chk("rec_chan", bus.rec_chan, e[254:251]);
                end
                last_acc = bus.rec_data; last_chan = bus.rec_chan;
            end
            pv = bus.rec_valid; pblk = bus.rec_valid && !bus.rec_ready && !rst; pdata = bus.rec_data;
            if (rst) model_reset();
            else if (cap_vld) model_step(bus.fifo_dout);
            take = bus.fifo_rd_en; take_cyc = cyc;
            if (take) chk("fifo_underflow", fq.size() == 0, 1'b0);
            @(posedge clk);
            cyc++;
            #1;
            cap_vld = take;
            if (take && fq.size() > 0) begin
                bus.fifo_dout = fq.pop_front();
                if (bus.fifo_dout == 32'hC0000001 && rd0_cyc < 0) rd0_cyc = take_cyc;
            end
            bus.fifo_empty = (fq.size() == 0) || (toggle && cyc[0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, r0;
        bus.rec_ready = 1'b1;
        rst = 1'b1;
        fq.push_back(IW7);
        push_rec(32'hC0000001, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rec_valid", bus.rec_valid, 1'b0);
        chk("rst_rec_data", bus.rec_data, 256'h0);
        chk("rst_rec_chan", bus.rec_chan, 4'h0);
        chk("rst_rec_count", rec_count, 32'h0);
        chk("rst_idle_count", idle_count, 32'h0);
        chk("rst_sync_err", sync_err_count, 16'h0);
        chk("rst_in_sync", in_sync, 1'b0);
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        @(posedge clk); #2; rst = 1'b0;

        // sync + first data record
        wait_drain("t1");
        chk("t1_in_sync", in_sync, 1'b1);
        chk("t1_rec_count", rec_count, 32'd1);
        chk("t1_latency", rise_cyc - rd0_cyc, 9);
        chk("t1_word0", last_acc[255:224], 32'hC0000001);
        chk("t1_chan", last_chan, 4'd8);

        // three idle records, read enable must stay high for all 24 words
        r0 = n_rise;
        @(posedge clk); #2;
        repeat (3) push_idle();
        @(negedge clk);
        n = 0;
        while (!bus.fifo_rd_en && n < 20) begin @(negedge clk); n++; end
        hi = 0;
        while (bus.fifo_rd_en && hi < 40) begin hi++; @(negedge clk); end
        chk("t2_rd_en_run", hi, 24);
        wait_drain("t2");
        chk("t2_idle_count", idle_count, 32'd3);
        chk("t2_no_rec", n_rise - r0, 0);

        // framing error on word 0, resync, next record forwarded
        @(posedge clk); #2;
        fq.push_back(32'h12345678); fq.push_back(32'h11111111); fq.push_back(32'hDEADBEEF);
        fq.push_back(IW7);
        push_rec(32'h98000002, 32'h20);
        n = 0;
        while (sync_err_count != 16'd1 && n < 100) begin @(negedge clk); n++; end
        chk("t3_err", sync_err_count, 16'd1);
        chk("t3_in_sync", in_sync, 1'b0);
        wait_drain("t3");
        chk("t3_rec_count", rec_count, 32'd2);
        chk("t3_chan", last_chan, 4'd3);

        // backpressure with three queued records
        @(posedge clk); #2;
        bus.rec_ready = 1'b0;
        push_rec(32'h80000003, 32'h30);
        push_rec(32'h80000004, 32'h40);
        push_rec(32'h80000005, 32'h50);
        repeat (40) @(negedge clk);
        chk("t4_valid", bus.rec_valid, 1'b1);
        chk("t4_data", bus.rec_data, {32'h80000003, 32'h31, 32'h32, 32'h33,
                                      32'h34, 32'h35, 32'h36, 32'h37});
        chk("t4_rd_stalled", bus.fifo_rd_en, 1'b0);
        chk("t4_fifo_left", fq.size(), 8);
        chk("t4_rec_count", rec_count, 32'd3);
        repeat (6) begin
            @(posedge clk); #2; bus.rec_ready = 1'b1;
            @(posedge clk); #2; bus.rec_ready = 1'b0;
            repeat (12) @(posedge clk);
        end
        #2; bus.rec_ready = 1'b1;
        wait_drain("t4");
        chk("t4_rec_count_end", rec_count, 32'd5);
        chk("t4_scoreboard", m_exp.size(), 0);

        // FIFO empty every other cycle
        @(posedge clk); #2;
        toggle = 1;
        push_rec(32'hA8000006, 32'h60);
        wait_drain("t5");
        toggle = 0;
        chk("t5_rec_count", rec_count, 32'd6);
        chk("t5_data", last_acc, {32'hA8000006, 32'h61, 32'h62, 32'h63,
                                  32'h64, 32'h65, 32'h66, 32'h67});

        // reset with a pending output and half a record assembled
        @(posedge clk); #2;
        bus.rec_ready = 1'b0;
        push_rec(32'h80000007, 32'h70);
        fq.push_back(32'h88000008); fq.push_back(32'h81); fq.push_back(32'h82); fq.push_back(32'h83);
        repeat (30) @(negedge clk);
        chk("t6_pre_valid", bus.rec_valid, 1'b1);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("t6_rec_valid", bus.rec_valid, 1'b0);
        chk("t6_rec_data", bus.rec_data, 256'h0);
        chk("t6_rec_count", rec_count, 32'h0);
        chk("t6_idle_count", idle_count, 32'h0);
        chk("t6_in_sync", in_sync, 1'b0);
        @(posedge clk); #2;
        bus.rec_ready = 1'b1;
        for (int k = 4; k < 8; k++) fq.push_back(32'h80 + k);
        push_rec(32'h90000009, 32'h90);
        fq.push_back(IW7);
        push_rec(32'hB8000010, 32'h100);
        wait_drain("t6");
        chk("t6_rec_count_end", rec_count, 32'd1);
        chk("t6_data", last_acc, {32'hB8000010, 32'h101, 32'h102, 32'h103,
                                  32'h104, 32'h105, 32'h106, 32'h107});
        chk("t6_chan", last_chan, 4'd7);
        chk("final_scoreboard", m_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
